// File: rtl/isp_pkg.sv
// Shared constants for the 3x3 window generator: default pixel width,
// window geometry and helpers that map (row, col) of a tap to its Win slice.
package isp_pkg;

  localparam int DW_DEF      = 16;
  localparam int WIN_SIDE    = 3;
  localparam int WIN_TAPS    = WIN_SIDE * WIN_SIDE;
  localparam int WIN_W       = WIN_TAPS * DW_DEF;
  localparam int SL_TOP_LEFT = 0;
  localparam int SL_CURRENT  = WIN_TAPS - 1;

  function automatic int slice_idx(input int i, input int j);
    return WIN_SIDE * i + j;
  endfunction

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line memory: one write port, one registered read port,
// no reset on contents or read data.
module line_ram #(
  parameter int DEPTH = 640,
  parameter int DW    = 16,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/win3x3_gen.sv
// Raster-scan 3x3 window generator: two line memories feed a 3x3 shift
// array; a window is emitted two clocks after each pixel with row>=2, col>=2.
module win3x3_gen
  import isp_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = DW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DW-1:0]          Din,
  input  logic                   dataEn,
  input  logic                   sof,
  output logic [WIN_TAPS*DW-1:0] Win,
  output logic                   WinEn,
  output logic                   FrameDone
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_col_last;
  logic          w_row_last;

  logic          r_vld_p1;
  logic [DW-1:0] r_din_p1;
  logic [CW-1:0] r_col_p1;
  logic          r_elig_p1;
  logic          r_last_p1;

  logic [DW-1:0] w_l1_q;
  logic [DW-1:0] w_l2_q;

  logic [WIN_TAPS-1:0][DW-1:0] r_tap_p2;
  logic [WIN_TAPS-1:0][DW-1:0] w_tap_nxt;

  // sof forces the pixel on this cycle to position (0,0)
  always_comb begin
    w_col      = sof ? '0 : r_col;
    w_row      = sof ? '0 : r_row;
    w_col_last = (int'(w_col) == IMG_W - 1);
    w_row_last = (int'(w_row) == IMG_H - 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (dataEn) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : w_row + 1'b1;
      end else begin
        r_col <= w_col + 1'b1;
        r_row <= w_row;
      end
    end else if (sof) begin
      r_col <= '0;
      r_row <= '0;
    end
  end

  // ---- p0 -> p1: accepted pixel and its position; line RAMs read here
  always_ff @(posedge clk) begin
    if (!rst_n) r_vld_p1 <= 1'b0;
    else        r_vld_p1 <= dataEn;
  end

  always_ff @(posedge clk) begin
    if (dataEn) begin
      r_din_p1  <= Din;
      r_col_p1  <= w_col;
      r_elig_p1 <= (int'(w_row) >= 2) && (int'(w_col) >= 2);
      r_last_p1 <= w_row_last && w_col_last;
    end
  end

  // Both memories are written one stage late so line2 can take line1's old word.
  line_ram #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_line1 (
    .clk     (clk),
    .i_we    (r_vld_p1),
    .i_waddr (r_col_p1),
    .i_wdata (r_din_p1),
    .i_re    (dataEn),
    .i_raddr (w_col),
    .o_rdata (w_l1_q)
  );

  line_ram #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_line2 (
    .clk     (clk),
    .i_we    (r_vld_p1),
    .i_waddr (r_col_p1),
    .i_wdata (w_l1_q),
    .i_re    (dataEn),
    .i_raddr (w_col),
    .o_rdata (w_l2_q)
  );

  // ---- p1 -> p2: shift window left, new column = {row r-2, r-1, r}
  assign w_tap_nxt = {r_din_p1, r_tap_p2[8], r_tap_p2[7],
                      w_l1_q,   r_tap_p2[5], r_tap_p2[4],
                      w_l2_q,   r_tap_p2[2], r_tap_p2[1]};

  always_ff @(posedge clk) begin
    if (r_vld_p1) r_tap_p2 <= w_tap_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Win       <= '0;
      WinEn     <= 1'b0;
      FrameDone <= 1'b0;
    end else begin
      WinEn     <= r_vld_p1 && r_elig_p1;
      FrameDone <= r_vld_p1 && r_last_p1;
      if (r_vld_p1 && r_elig_p1) Win <= w_tap_nxt;
    end
  end

endmodule

// File: tb/tb_win3x3_gen.sv
// Bench for win3x3_gen on an 8x6 image: image-level reference model of the
// expected window stream, directed frames plus randomized gaps/sof/reset.
module tb_win3x3_gen;
  import isp_pkg::*;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int D  = DW_DEF;
  localparam int WW = WIN_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dataEn;
  logic          sof;
  logic [D-1:0]  Din;
  logic [WW-1:0] Win;
  logic          WinEn;
  logic          FrameDone;

  win3x3_gen #(.IMG_W(W), .IMG_H(H), .DW(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Din       (Din),
    .dataEn    (dataEn),
    .sof       (sof),
    .Win       (Win),
    .WinEn     (WinEn),
    .FrameDone (FrameDone)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: current frame image, position, and a 2-deep output schedule
  logic [D-1:0]  img [H][W];
  int            pr, pc;
  logic          s1_en, s1_fd, vis_en, vis_fd;
  logic [WW-1:0] s1_win, vis_win;

  int            cyc_n = 0;
  int            pulses, fds;
  logic [WW-1:0] cap [64];
  int            fd_cyc [4];

  task automatic model_edge(input logic de, input logic s, input logic rn, input logic [D-1:0] d);
    if (!rn) begin
      pr = 0; pc = 0;
      vis_en = 1'b0; vis_fd = 1'b0; vis_win = '0;
      s1_en = 1'b0; s1_fd = 1'b0;
    end else begin
      vis_en = s1_en;
      vis_fd = s1_fd;
      if (s1_en) vis_win = s1_win;
      s1_en = 1'b0;
      s1_fd = 1'b0;
      if (de) begin
        if (s) begin pr = 0; pc = 0; end
        img[pr][pc] = d;
        if (pr >= 2 && pc >= 2) begin
          s1_en = 1'b1;
          s1_fd = (pr == H - 1) && (pc == W - 1);
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              s1_win[D*slice_idx(i, j) +: D] = img[pr-2+i][pc-2+j];
        end
        pc++;
        if (pc == W) begin
          pc = 0;
          pr++;
          if (pr == H) pr = 0;
        end
      end else if (s) begin
        pr = 0; pc = 0;
      end
    end
  endtask

  task automatic step(input logic de, input logic s, input logic rn, input logic [D-1:0] d);
    rst_n = rn; dataEn = de; sof = s; Din = d;
    @(posedge clk);
    cyc_n++;
    model_edge(de, s, rn, d);
    @(negedge clk);
    chk("WinEn", WW'(WinEn), WW'(vis_en));
    chk("FrameDone", WW'(FrameDone), WW'(vis_fd));
    chk("Win", Win, vis_win);
    if (WinEn === 1'b1) begin
      if (pulses < 64) cap[pulses] = Win;
      pulses++;
    end
    if (FrameDone === 1'b1) begin
      if (fds < 4) fd_cyc[fds] = cyc_n;
      fds++;
    end
  endtask

  function automatic logic [D-1:0] px(input int p);
    return D'(16 * (p / W) + (p % W));
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1, D'($urandom));
  endtask

  task automatic frame(input bit gap, input bit first_sof);
    for (int p = 0; p < W * H; p++) begin
      step(1'b1, first_sof && (p == 0), 1'b1, px(p));
      if (gap) step(1'b0, 1'b0, 1'b1, D'($urandom));
    end
  endtask

  task automatic clr_stats();
    pulses = 0;
    fds = 0;
  endtask

  function automatic logic [WW-1:0] first_win();
    logic [WW-1:0] r;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        r[D*slice_idx(i, j) +: D] = D'(16 * i + j);
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [WW-1:0] fw;
    fw = first_win();
    rst_n = 1'b0; dataEn = 1'b0; sof = 1'b0; Din = '0;
    pr = 0; pc = 0;
    s1_en = 1'b0; s1_fd = 1'b0; s1_win = '0;
    vis_en = 1'b0; vis_fd = 1'b0; vis_win = '0;
    clr_stats();
    @(negedge clk);

    // reset, including a cycle with dataEn/sof asserted under reset
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, D'($urandom));
    step(1'b0, 1'b0, 1'b0, '0);
    idle(2);

    // continuous frame
    clr_stats();
    frame(1'b0, 1'b0);
    idle(3);
    chk("t1_pulses", WW'(pulses), WW'(24));
    chk("t1_fd", WW'(fds), WW'(1));
    chk("t1_first", cap[0], fw);
    chk("t1_last_cur", WW'(cap[23][D*SL_CURRENT +: D]), WW'(16'h57));
    chk("wrap_3_7_cur", WW'(cap[11][D*SL_CURRENT +: D]), WW'(16'h37));
    chk("wrap_4_2_tl", WW'(cap[12][D*SL_TOP_LEFT +: D]), WW'(16'h20));

    // dataEn toggling 1,0
    clr_stats();
    frame(1'b1, 1'b0);
    idle(3);
    chk("t2_pulses", WW'(pulses), WW'(24));
    chk("t2_fd", WW'(fds), WW'(1));
    chk("t2_first", cap[0], fw);
    chk("t2_last_cur", WW'(cap[23][D*SL_CURRENT +: D]), WW'(16'h57));

    // reset for one cycle right after pixel (3,4)
    clr_stats();
    for (int p = 0; p <= 28; p++) step(1'b1, 1'b0, 1'b1, px(p));
    step(1'b0, 1'b0, 1'b0, '0);
    frame(1'b0, 1'b0);
    idle(3);
    chk("t4_pulses", WW'(pulses), WW'(32));
    chk("t4_first_new", cap[8], fw);
    chk("t4_fd", WW'(fds), WW'(1));

    // sof with dataEn at pixel index 20
    clr_stats();
    for (int p = 0; p < 20; p++) step(1'b1, 1'b0, 1'b1, px(p));
    frame(1'b0, 1'b1);
    idle(3);
    chk("t5_pulses", WW'(pulses), WW'(26));
    chk("t5_first_new", cap[2], fw);
    chk("t5_fd", WW'(fds), WW'(1));

    // sof without dataEn clears position
    clr_stats();
    for (int p = 0; p < 10; p++) step(1'b1, 1'b0, 1'b1, D'($urandom));
    step(1'b0, 1'b1, 1'b1, D'($urandom));
    frame(1'b0, 1'b0);
    idle(3);
    chk("t6_pulses", WW'(pulses), WW'(24));
    chk("t6_first", cap[0], fw);

    // two back-to-back frames
    clr_stats();
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    idle(3);
    chk("t7_fd", WW'(fds), WW'(2));
    chk("t7_fd_gap", WW'(fd_cyc[1] - fd_cyc[0]), WW'(48));

    // randomized gaps, data, occasional sof and reset
    clr_stats();
    for (int k = 0; k < 1500; k++)
      step(($urandom % 10) < 7, ($urandom % 80) == 0, ($urandom % 300) != 0, D'($urandom));
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
